pc_sequencer: RTL and testbench

Program-counter sequencer for the FRANK6000 core. It owns the PC register and a circular hardware return-address stack, and it computes the next PC from the control-unit outputs (PCw, jump, j_mode, call, return). It sits between the control unit and the instruction memory address port. It sequences the datapath for sequential fetch, absolute jump, conditional skip, subroutine call and the two-cycle return.

---
 rtl/pc_sequencer_pkg.sv | 11 +
 rtl/pc_sequencer_if.sv | 33 +++
 rtl/pc_sequencer_return_stack.sv | 77 +++++++
 rtl/pc_sequencer.sv | 58 +++++
 tb/tb_pc_sequencer.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared next-PC mode encodings for the FRANK6000 PC sequencer and control unit.
package pc_sequencer_pkg;

  typedef logic [1:0] jmode_t;

  localparam jmode_t JM_SEQ  = 2'b00;
  localparam jmode_t JM_ABS  = 2'b01;
  localparam jmode_t JM_RET  = 2'b10;
  localparam jmode_t JM_SKIP = 2'b11;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control-unit <-> PC sequencer bundle: next-PC controls in, PC and stack status out.
interface pc_sequencer_if #(
  parameter int PC_W        = 10,
  parameter int STACK_DEPTH = 8
);
  import pc_sequencer_pkg::*;

  localparam int CNT_W = $clog2(STACK_DEPTH) + 1;

  logic             pc_en;
  logic             jump;
  jmode_t           j_mode;
  logic             call;
  logic             ret;
  logic [PC_W-1:0]  target;
  logic             skip_cond;
  logic             clr_err;
  logic [PC_W-1:0]  pc;
  logic [CNT_W-1:0] stack_cnt;
  logic             stack_ovf;
  logic             stack_unf;

  modport master (
    output pc_en, jump, j_mode, call, ret, target, skip_cond, clr_err,
    input  pc, stack_cnt, stack_ovf, stack_unf
  );

  modport slave (
    input  pc_en, jump, j_mode, call, ret, target, skip_cond, clr_err,
    output pc, stack_cnt, stack_ovf, stack_unf
  );

endinterface

// File: rtl/pc_sequencer_return_stack.sv
// Circular hardware return-address stack with a registered top-of-stack latch
// and sticky overflow/underflow flags.
module pc_sequencer_return_stack #(
  parameter int              PC_W        = 10,
  parameter int              STACK_DEPTH = 8,
  parameter logic [PC_W-1:0] RESET_VEC   = '0,
  localparam int             SP_W        = $clog2(STACK_DEPTH),
  localparam int             CNT_W       = SP_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [PC_W-1:0]  i_push_data,
  input  logic             i_clr_err,
  output logic [PC_W-1:0]  o_tos,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_ovf,
  output logic             o_unf
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(STACK_DEPTH);

  logic [PC_W-1:0]  r_mem [STACK_DEPTH];
  logic [SP_W-1:0]  r_sp;
  logic [CNT_W-1:0] r_cnt;
  logic [PC_W-1:0]  r_tos;
  logic             r_ovf;
  logic             r_unf;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;

  assign w_full  = (r_cnt == FULL);
  assign w_empty = (r_cnt == '0);
  // A push in the same cycle swallows the pop completely.
  assign w_pop   = i_pop & ~i_push;

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_sp] <= i_push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sp  <= '0;
      r_cnt <= '0;
      r_tos <= RESET_VEC;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (i_push) begin
        r_sp <= r_sp + SP_W'(1);
        if (!w_full) r_cnt <= r_cnt + CNT_W'(1);
      end else if (w_pop) begin
        if (!w_empty) begin
          r_tos <= r_mem[r_sp - SP_W'(1)];
          r_sp  <= r_sp - SP_W'(1);
          r_cnt <= r_cnt - CNT_W'(1);
        end else begin
          r_tos <= RESET_VEC;
        end
      end

      if (i_push && w_full)      r_ovf <= 1'b1;
      else if (i_clr_err)        r_ovf <= 1'b0;

      if (w_pop && w_empty)      r_unf <= 1'b1;
      else if (i_clr_err)        r_unf <= 1'b0;
    end
  end

  assign o_tos = r_tos;
  assign o_cnt = r_cnt;
  assign o_ovf = r_ovf;
  assign o_unf = r_unf;

endmodule

// File: rtl/pc_sequencer.sv
// FRANK6000 program-counter sequencer: PC register, next-PC mux and the
// return-address stack that backs CALL/RETRN.
module pc_sequencer #(
  parameter int              PC_W        = 10,
  parameter int              STACK_DEPTH = 8,
  parameter logic [PC_W-1:0] RESET_VEC   = '0
) (
  input  logic           clk,
  input  logic           rst,
  pc_sequencer_if.slave  bus
);
  import pc_sequencer_pkg::*;

  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_inc;
  logic [PC_W-1:0] w_pc_nxt;
  logic [PC_W-1:0] w_tos;
  logic            w_push;

  assign w_pc_inc = r_pc + PC_W'(1);
  assign w_push   = bus.pc_en & bus.jump & bus.call & (bus.j_mode == JM_ABS);

  // Return mode is checked first and does not need jump asserted.
  always_comb begin
    w_pc_nxt = w_pc_inc;
    if (bus.j_mode == JM_RET)
      w_pc_nxt = w_tos;
    else if (bus.jump && (bus.j_mode == JM_ABS))
      w_pc_nxt = bus.target;
    else if (bus.jump && (bus.j_mode == JM_SKIP) && bus.skip_cond)
      w_pc_nxt = r_pc + PC_W'(2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_pc <= RESET_VEC;
    else if (bus.pc_en) r_pc <= w_pc_nxt;
  end

  pc_sequencer_return_stack #(
    .PC_W        (PC_W),
    .STACK_DEPTH (STACK_DEPTH),
    .RESET_VEC   (RESET_VEC)
  ) u_stack (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_pop       (bus.ret),
    .i_push_data (w_pc_inc),
    .i_clr_err   (bus.clr_err),
    .o_tos       (w_tos),
    .o_cnt       (bus.stack_cnt),
    .o_ovf       (bus.stack_ovf),
    .o_unf       (bus.stack_unf)
  );

  assign bus.pc = r_pc;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer: sequential fetch, jump/skip, call/return,
// stack overflow/underflow, error clearing and asynchronous reset.
module tb_pc_sequencer;

  localparam int PC_W  = 10;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   passed = 0;

  pc_sequencer_if #(.PC_W(PC_W), .STACK_DEPTH(DEPTH)) bus ();

  pc_sequencer #(
    .PC_W        (PC_W),
    .STACK_DEPTH (DEPTH),
    .RESET_VEC   (10'h000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    bus.pc_en     = 1'b0;
    bus.jump      = 1'b0;
    bus.j_mode    = 2'b00;
    bus.call      = 1'b0;
    bus.ret       = 1'b0;
    bus.target    = '0;
    bus.skip_cond = 1'b0;
    bus.clr_err   = 1'b0;
  endtask

  task automatic set_pc(input logic [PC_W-1:0] v);
    idle();
    bus.pc_en  = 1'b1;
    bus.jump   = 1'b1;
    bus.j_mode = 2'b01;
    bus.target = v;
    cyc();
    idle();
  endtask

  task automatic call_from(input logic [PC_W-1:0] from, input logic [PC_W-1:0] tgt);
    set_pc(from);
    bus.pc_en  = 1'b1;
    bus.jump   = 1'b1;
    bus.j_mode = 2'b01;
    bus.call   = 1'b1;
    bus.target = tgt;
    cyc();
    idle();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle();
    #12;
    checks++; if (bus.pc !== 10'h000) $display("FAIL reset_pc: got %h want %h", bus.pc, 10'h000); else passed++;
    checks++; if (bus.stack_cnt !== 4'd0) $display("FAIL reset_cnt: got %0d want 0", bus.stack_cnt); else passed++;
    checks++; if (bus.stack_ovf !== 1'b0) $display("FAIL reset_ovf: got %b want 0", bus.stack_ovf); else passed++;
    checks++; if (bus.stack_unf !== 1'b0) $display("FAIL reset_unf: got %b want 0", bus.stack_unf); else passed++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_sequential;
    bus.pc_en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      cyc();
      checks++;
      if (bus.pc !== 10'(i)) $display("FAIL seq_pc%0d: got %h want %h", i, bus.pc, 10'(i));
      else passed++;
    end
    idle();
    checks++; if (bus.stack_cnt !== 4'd0) $display("FAIL seq_cnt: got %0d want 0", bus.stack_cnt); else passed++;
    checks++; if ({bus.stack_ovf, bus.stack_unf} !== 2'b00) $display("FAIL seq_flags: got %b want 00", {bus.stack_ovf, bus.stack_unf}); else passed++;
  endtask

  task automatic test_call_return;
    set_pc(10'h005);
    checks++; if (bus.pc !== 10'h005) $display("FAIL cr_setpc: got %h want %h", bus.pc, 10'h005); else passed++;
    bus.pc_en = 1'b1; bus.jump = 1'b1; bus.j_mode = 2'b01; bus.call = 1'b1; bus.target = 10'h100;
    cyc(); idle();
    checks++; if (bus.pc !== 10'h100) $display("FAIL cr_call_pc: got %h want %h", bus.pc, 10'h100); else passed++;
    checks++; if (bus.stack_cnt !== 4'd1) $display("FAIL cr_call_cnt: got %0d want 1", bus.stack_cnt); else passed++;
    bus.ret = 1'b1;
    cyc(); idle();
    checks++; if (bus.stack_cnt !== 4'd0) $display("FAIL cr_pop_cnt: got %0d want 0", bus.stack_cnt); else passed++;
    checks++; if (bus.pc !== 10'h100) $display("FAIL cr_pop_hold: got %h want %h", bus.pc, 10'h100); else passed++;
    bus.pc_en = 1'b1; bus.j_mode = 2'b10;
    cyc(); idle();
    checks++; if (bus.pc !== 10'h006) $display("FAIL cr_ret_pc: got %h want %h", bus.pc, 10'h006); else passed++;
  endtask

  task automatic test_skip_wrap;
    set_pc(10'h020);
    bus.pc_en = 1'b1; bus.jump = 1'b1; bus.j_mode = 2'b11; bus.skip_cond = 1'b1;
    cyc(); idle();
    checks++; if (bus.pc !== 10'h022) $display("FAIL skip_taken: got %h want %h", bus.pc, 10'h022); else passed++;
    set_pc(10'h020);
    bus.pc_en = 1'b1; bus.jump = 1'b1; bus.j_mode = 2'b11; bus.skip_cond = 1'b0;
    cyc(); idle();
    checks++; if (bus.pc !== 10'h021) $display("FAIL skip_not: got %h want %h", bus.pc, 10'h021); else passed++;
    set_pc(10'h3FF);
    bus.pc_en = 1'b1; bus.j_mode = 2'b00;
    cyc(); idle();
    checks++; if (bus.pc !== 10'h000) $display("FAIL wrap_pc: got %h want %h", bus.pc, 10'h000); else passed++;
    bus.jump = 1'b1; bus.j_mode = 2'b01; bus.target = 10'h123;
    cyc(); idle();
    checks++; if (bus.pc !== 10'h000) $display("FAIL hold_pc: got %h want %h", bus.pc, 10'h000); else passed++;
  endtask

  task automatic test_overflow;
    for (int k = 1; k <= 9; k++) begin
      call_from(10'(k * 16), 10'h200);
      if (k == 8) begin
        checks++; if (bus.stack_cnt !== 4'd8) $display("FAIL ovf_cnt8: got %0d want 8", bus.stack_cnt); else passed++;
        checks++; if (bus.stack_ovf !== 1'b0) $display("FAIL ovf_early: got %b want 0", bus.stack_ovf); else passed++;
      end
    end
    checks++; if (bus.stack_cnt !== 4'd8) $display("FAIL ovf_cnt9: got %0d want 8", bus.stack_cnt); else passed++;
    checks++; if (bus.stack_ovf !== 1'b1) $display("FAIL ovf_flag: got %b want 1", bus.stack_ovf); else passed++;
    bus.ret = 1'b1;
    cyc(); idle();
    // Each cycle returns to the previously popped address while popping the next.
    for (int i = 0; i < 8; i++) begin
      bus.ret = (i < 7); bus.pc_en = 1'b1; bus.j_mode = 2'b10;
      cyc(); idle();
      checks++;
      if (bus.pc !== 10'((9 - i) * 16 + 1)) $display("FAIL ovf_pop%0d: got %h want %h", i, bus.pc, 10'((9 - i) * 16 + 1));
      else passed++;
    end
    checks++; if (bus.stack_cnt !== 4'd0) $display("FAIL ovf_drain_cnt: got %0d want 0", bus.stack_cnt); else passed++;
    checks++; if (bus.stack_ovf !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", bus.stack_ovf); else passed++;
  endtask

  task automatic test_underflow_clear;
    set_pc(10'h055);
    bus.ret = 1'b1;
    cyc(); idle();
    checks++; if (bus.stack_unf !== 1'b1) $display("FAIL unf_flag: got %b want 1", bus.stack_unf); else passed++;
    checks++; if (bus.stack_cnt !== 4'd0) $display("FAIL unf_cnt: got %0d want 0", bus.stack_cnt); else passed++;
    bus.pc_en = 1'b1; bus.j_mode = 2'b10;
    cyc(); idle();
    checks++; if (bus.pc !== 10'h000) $display("FAIL unf_tos: got %h want %h", bus.pc, 10'h000); else passed++;
    bus.clr_err = 1'b1;
    cyc(); idle();
    checks++; if ({bus.stack_ovf, bus.stack_unf} !== 2'b00) $display("FAIL clr_flags: got %b want 00", {bus.stack_ovf, bus.stack_unf}); else passed++;
    bus.ret = 1'b1; bus.clr_err = 1'b1;
    cyc(); idle();
    checks++; if (bus.stack_unf !== 1'b1) $display("FAIL set_beats_clr: got %b want 1", bus.stack_unf); else passed++;
    bus.clr_err = 1'b1;
    cyc(); idle();
    checks++; if (bus.stack_unf !== 1'b0) $display("FAIL clr_again: got %b want 0", bus.stack_unf); else passed++;
  endtask

  task automatic test_push_pop_same;
    call_from(10'h030, 10'h200);
    call_from(10'h040, 10'h200);
    call_from(10'h050, 10'h200);
    bus.ret = 1'b1;
    cyc(); idle();
    checks++; if (bus.stack_cnt !== 4'd2) $display("FAIL pp_cnt2: got %0d want 2", bus.stack_cnt); else passed++;
    set_pc(10'h060);
    bus.pc_en = 1'b1; bus.jump = 1'b1; bus.j_mode = 2'b01; bus.call = 1'b1; bus.ret = 1'b1; bus.target = 10'h300;
    cyc(); idle();
    checks++; if (bus.stack_cnt !== 4'd3) $display("FAIL pp_cnt3: got %0d want 3", bus.stack_cnt); else passed++;
    checks++; if (bus.pc !== 10'h300) $display("FAIL pp_pc: got %h want %h", bus.pc, 10'h300); else passed++;
    bus.pc_en = 1'b1; bus.jump = 1'b1; bus.j_mode = 2'b10;
    cyc(); idle();
    checks++; if (bus.pc !== 10'h051) $display("FAIL pp_tos: got %h want %h", bus.pc, 10'h051); else passed++;
    checks++; if (bus.stack_unf !== 1'b0) $display("FAIL pp_unf: got %b want 0", bus.stack_unf); else passed++;
  endtask

  task automatic test_async_reset;
    set_pc(10'h040);
    checks++; if (bus.stack_cnt !== 4'd3) $display("FAIL ar_pre_cnt: got %0d want 3", bus.stack_cnt); else passed++;
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.pc !== 10'h000) $display("FAIL ar_pc: got %h want %h", bus.pc, 10'h000); else passed++;
    checks++; if (bus.stack_cnt !== 4'd0) $display("FAIL ar_cnt: got %0d want 0", bus.stack_cnt); else passed++;
    cyc();
    rst = 1'b0;
    bus.pc_en = 1'b1;
    cyc(); idle();
    checks++; if (bus.pc !== 10'h001) $display("FAIL ar_resume: got %h want %h", bus.pc, 10'h001); else passed++;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_call_return();
    test_skip_wrap();
    test_overflow();
    test_underflow_clear();
    test_push_pop_same();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
